// File: rtl/wb_counter_bank_if.sv
// Wishbone slave bundle for the counter bank: the management SoC drives the
// request side (master modport) and the bank returns ack and read data (slave modport).
interface wb_counter_bank_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_counter_bank.sv
// Bank of CHANNELS up/down counters with limit, one-shot and per-channel IRQ on Wishbone.
// Define COUNTER_BANK_LA_EN to add the logic-analyser force-load ports (la_load/la_value).
module wb_counter_bank #(
  parameter int CHANNELS = 4,
  parameter int BITS     = 16
) (
  input  logic                     clk,
  input  logic                     nreset,
  wb_counter_bank_if.slave         wbs,
`ifdef COUNTER_BANK_LA_EN
  input  logic [CHANNELS-1:0]      la_load,
  input  logic [BITS-1:0]          la_value,
`endif
  output logic [CHANNELS*BITS-1:0] count_o,
  output logic [CHANNELS-1:0]      irq_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [BITS-1:0]     r_count [CHANNELS];
  logic [BITS-1:0]     r_limit [CHANNELS];
  logic [CHANNELS-1:0] r_en;
  logic [CHANNELS-1:0] r_dir;
  logic [CHANNELS-1:0] r_oneshot;
  logic [CHANNELS-1:0] r_irq_en;
  logic [CHANNELS-1:0] r_flag;
  logic                r_ack;
  logic [31:0]         r_dat;

  logic                w_accept;
  logic [3:0]          w_ch;
  logic [1:0]          w_reg;
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_wr_ctrl;
  logic [CHANNELS-1:0] w_wr_count;
  logic [CHANNELS-1:0] w_wr_limit;
  logic [CHANNELS-1:0] w_wr_status;
  logic [CHANNELS-1:0] w_step;
  logic [CHANNELS-1:0] w_term;
  logic [BITS-1:0]     w_next [CHANNELS];
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_accept = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
  assign w_ch     = wbs.wbs_adr_i[7:4];
  assign w_reg    = wbs.wbs_adr_i[3:2];
  assign w_unused = &{1'b0, wbs.wbs_adr_i[31:8], wbs.wbs_adr_i[1:0]};

  // Decode and per-channel step; channel numbers past CHANNELS never match, so
  // those accesses are acked but touch nothing.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_hit[c]       = w_accept & (w_ch == 4'(c));
      w_wr_ctrl[c]   = w_hit[c] & wbs.wbs_we_i & (w_reg == REG_CTRL);
      w_wr_count[c]  = w_hit[c] & wbs.wbs_we_i & (w_reg == REG_COUNT);
      w_wr_limit[c]  = w_hit[c] & wbs.wbs_we_i & (w_reg == REG_LIMIT);
      w_wr_status[c] = w_hit[c] & wbs.wbs_we_i & (w_reg == REG_STATUS);
      w_step[c]      = r_en[c] & ~w_wr_count[c];
`ifdef COUNTER_BANK_LA_EN
      w_step[c]      = w_step[c] & ~la_load[c];
`endif
      if (r_dir[c]) begin
        w_term[c] = w_step[c] & (r_count[c] == '0);
        w_next[c] = (r_count[c] == '0) ? r_limit[c] : r_count[c] - BITS'(1);
      end else begin
        w_term[c] = w_step[c] & (r_count[c] == r_limit[c]);
        w_next[c] = (r_count[c] == r_limit[c]) ? '0 : r_count[c] + BITS'(1);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_ch == 4'(c)) begin
        case (w_reg)
          REG_CTRL:   w_rdata = {28'd0, r_irq_en[c], r_oneshot[c], r_dir[c], r_en[c]};
          REG_COUNT:  w_rdata = 32'(r_count[c]);
          REG_LIMIT:  w_rdata = 32'(r_limit[c]);
          default:    w_rdata = {31'd0, r_flag[c]};
        endcase
      end
    end
  end

  // Register update: bus write beats LA load beats the count step.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_en      <= '0;
      r_dir     <= '0;
      r_oneshot <= '0;
      r_irq_en  <= '0;
      r_flag    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_count[c] <= '0;
        r_limit[c] <= '0;
      end
    end else begin
      r_ack <= w_accept;
      if (w_accept && !wbs.wbs_we_i) r_dat <= w_rdata;

      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr_count[c]) begin
          r_count[c] <= BITS'(lane_merge(32'(r_count[c]), wbs.wbs_dat_i, wbs.wbs_sel_i));
        end
`ifdef COUNTER_BANK_LA_EN
        else if (la_load[c]) begin
          r_count[c] <= la_value;
        end
`endif
        else if (w_step[c]) begin
          r_count[c] <= w_next[c];
        end

        if (w_wr_limit[c]) begin
          r_limit[c] <= BITS'(lane_merge(32'(r_limit[c]), wbs.wbs_dat_i, wbs.wbs_sel_i));
        end

        // A CTRL write in the terminal cycle overrides the one-shot disable.
        if (w_wr_ctrl[c] && wbs.wbs_sel_i[0]) begin
          r_en[c]      <= wbs.wbs_dat_i[0];
          r_dir[c]     <= wbs.wbs_dat_i[1];
          r_oneshot[c] <= wbs.wbs_dat_i[2];
          r_irq_en[c]  <= wbs.wbs_dat_i[3];
        end else if (w_term[c] && r_oneshot[c]) begin
          r_en[c] <= 1'b0;
        end

        if (w_term[c]) begin
          r_flag[c] <= 1'b1;
        end else if (w_wr_status[c] && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) begin
          r_flag[c] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count_out
    assign count_o[g*BITS +: BITS] = r_count[g];
  end

  assign irq_o         = r_flag & r_irq_en;
  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;

endmodule

// File: tb/tb_wb_counter_bank.sv
// Self-checking bench for wb_counter_bank (CHANNELS=4, BITS=16): directed scenarios plus
// randomized bus traffic checked against a behavioural model of the register bank.
module tb_wb_counter_bank;
  localparam int NCH = 4;
  localparam int BW  = 16;
  localparam int unsigned MOD = 32'd1 << BW;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic [NCH*BW-1:0] count_o;
  logic [NCH-1:0]    irq_o;
  logic [NCH-1:0]    la_load = '0;
  logic [BW-1:0]     la_value = '0;

  int n_pass = 0;
  int n_total = 0;

  wb_counter_bank_if bus();

  wb_counter_bank dut (
    .clk      (clk),
    .nreset   (nreset),
    .wbs      (bus),
`ifdef COUNTER_BANK_LA_EN
    .la_load  (la_load),
    .la_value (la_value),
`endif
    .count_o  (count_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  // Behavioural model of the register bank, one update per rising edge.
  int unsigned m_count [NCH];
  int unsigned m_limit [NCH];
  bit m_en [NCH];
  bit m_dir [NCH];
  bit m_os [NCH];
  bit m_ien [NCH];
  bit m_flag [NCH];
  bit m_ack;
  logic [31:0] m_dat;

  function automatic int unsigned lanes(input int unsigned old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v % MOD;
  endfunction

  function automatic logic [31:0] model_read(input int ch, input int rg);
    if (ch >= NCH) return 32'd0;
    case (rg)
      0: return {28'd0, m_ien[ch], m_os[ch], m_dir[ch], m_en[ch]};
      1: return m_count[ch];
      2: return m_limit[ch];
      default: return {31'd0, m_flag[ch]};
    endcase
  endfunction

  function automatic logic [NCH*BW-1:0] exp_count();
    logic [NCH*BW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*BW +: BW] = BW'(m_count[c]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_irq();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_flag[c] & m_ien[c];
    return v;
  endfunction

  always @(posedge clk or negedge nreset) begin : model
    bit acc, hit, term;
    int unsigned nxt;
    int ch, rg;
    if (!nreset) begin
      m_ack = 0;
      m_dat = '0;
      for (int c = 0; c < NCH; c++) begin
        m_count[c] = 0; m_limit[c] = 0; m_en[c] = 0; m_dir[c] = 0;
        m_os[c] = 0; m_ien[c] = 0; m_flag[c] = 0;
      end
    end else begin
      acc = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack;
      ch  = int'(bus.wbs_adr_i[7:4]);
      rg  = int'(bus.wbs_adr_i[3:2]);
      if (acc && !bus.wbs_we_i) m_dat = model_read(ch, rg);
      for (int c = 0; c < NCH; c++) begin
        hit  = acc && bus.wbs_we_i && (ch == c);
        term = 0;
        nxt  = m_count[c];
        if (m_en[c]) begin
          if (!m_dir[c]) begin
            if (m_count[c] == m_limit[c]) begin nxt = 0; term = 1; end
            else nxt = (m_count[c] + 1) % MOD;
          end else begin
            if (m_count[c] == 0) begin nxt = m_limit[c]; term = 1; end
            else nxt = m_count[c] - 1;
          end
        end
`ifdef COUNTER_BANK_LA_EN
        if (la_load[c]) begin nxt = la_value; term = 0; end
`endif
        if (hit && rg == 1) begin nxt = lanes(m_count[c], bus.wbs_dat_i, bus.wbs_sel_i); term = 0; end
        if (term && m_os[c]) m_en[c] = 0;
        if (hit && rg == 0 && bus.wbs_sel_i[0])
          {m_ien[c], m_os[c], m_dir[c], m_en[c]} = bus.wbs_dat_i[3:0];
        if (hit && rg == 2) m_limit[c] = lanes(m_limit[c], bus.wbs_dat_i, bus.wbs_sel_i);
        if (hit && rg == 3 && bus.wbs_sel_i[0] && bus.wbs_dat_i[0]) m_flag[c] = 0;
        if (term) m_flag[c] = 1;
        m_count[c] = nxt;
      end
      m_ack = acc;
    end
  end

  // Bus stimulus helpers: called at a falling edge, return at the falling edge where ack is seen.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 0;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
    bus.wbs_adr_i = a; bus.wbs_dat_i = d; bus.wbs_sel_i = s;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin got = 1; break; end
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    if (!got) begin
      n_total++;
      $display("FAIL wb_write_ack adr=%h got=no-ack exp=ack", a);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    bit got;
    got = 0;
    d = '0;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = a; bus.wbs_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin got = 1; d = bus.wbs_dat_o; break; end
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    if (!got) begin
      n_total++;
      $display("FAIL wb_read_ack adr=%h got=no-ack exp=ack", a);
    end
  endtask

  task automatic do_reset();
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    la_load = '0;
    nreset = 0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2 nreset = 0;
    #1;
    n_total++; if (count_o !== '0) $display("FAIL reset_count got=%h exp=0", count_o); else n_pass++;
    n_total++; if (irq_o !== '0) $display("FAIL reset_irq got=%b exp=0", irq_o); else n_pass++;
    n_total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL reset_ack got=%b exp=0", bus.wbs_ack_o); else n_pass++;
    n_total++; if (bus.wbs_dat_o !== '0) $display("FAIL reset_dat got=%h exp=0", bus.wbs_dat_o); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    nreset = 1;
    repeat (3) @(negedge clk);
    n_total++; if (count_o !== '0) $display("FAIL reset_idle got=%h exp=0", count_o); else n_pass++;
    wb_read(32'h00, d);
    n_total++; if (d !== 32'd0) $display("FAIL reset_ctrl0 got=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_up_wrap();
    logic e;
    do_reset();
    wb_write(32'h08, 32'd5, 4'hF);
    wb_write(32'h00, 32'h9, 4'hF);
    for (int k = 0; k < 8; k++) begin
      e = (k >= 6);
      n_total++;
      if (count_o[15:0] !== 16'(k % 6)) $display("FAIL up_count k=%0d got=%0d exp=%0d", k, count_o[15:0], k % 6);
      else n_pass++;
      n_total++;
      if (irq_o[0] !== e) $display("FAIL up_irq k=%0d got=%b exp=%b", k, irq_o[0], e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_down_oneshot();
    int dn [6];
    logic [31:0] d;
    dn = '{2, 1, 0, 3, 3, 3};
    do_reset();
    wb_write(32'h18, 32'd3, 4'hF);
    wb_write(32'h14, 32'd2, 4'hF);
    wb_write(32'h10, 32'h7, 4'hF);
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (count_o[31:16] !== 16'(dn[k])) $display("FAIL down_count k=%0d got=%0d exp=%0d", k, count_o[31:16], dn[k]);
      else n_pass++;
      @(negedge clk);
    end
    n_total++; if (irq_o[1] !== 1'b0) $display("FAIL down_irq got=%b exp=0", irq_o[1]); else n_pass++;
    wb_read(32'h1C, d);
    n_total++; if (d !== 32'd1) $display("FAIL down_flag got=%h exp=1", d); else n_pass++;
    wb_read(32'h10, d);
    n_total++; if (d !== 32'h6) $display("FAIL down_ctrl got=%h exp=6", d); else n_pass++;
  endtask

  task automatic test_w1c_race();
    do_reset();
    wb_write(32'h08, 32'd3, 4'hF);
    wb_write(32'h00, 32'h9, 4'hF);
    repeat (3) @(negedge clk);
    n_total++; if (count_o[15:0] !== 16'd3) $display("FAIL w1c_pre got=%0d exp=3", count_o[15:0]); else n_pass++;
    wb_write(32'h0C, 32'd1, 4'hF);
    n_total++; if (count_o[15:0] !== 16'd0) $display("FAIL w1c_wrap got=%0d exp=0", count_o[15:0]); else n_pass++;
    n_total++; if (irq_o[0] !== 1'b1) $display("FAIL w1c_race_irq got=%b exp=1", irq_o[0]); else n_pass++;
    wb_write(32'h0C, 32'd1, 4'hF);
    n_total++; if (irq_o[0] !== 1'b0) $display("FAIL w1c_clear_irq got=%b exp=0", irq_o[0]); else n_pass++;
    n_total++; if (count_o[15:0] !== 16'd2) $display("FAIL w1c_count got=%0d exp=2", count_o[15:0]); else n_pass++;
  endtask

  task automatic test_bus();
    logic [31:0] d;
    logic e;
    do_reset();
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = 32'h04; bus.wbs_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = (k % 2 == 0);
      n_total++;
      if (bus.wbs_ack_o !== e) $display("FAIL ack_pattern k=%0d got=%b exp=%b", k, bus.wbs_ack_o, e);
      else n_pass++;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    wb_write(32'h08, 32'hBEEF, 4'hF);
    wb_read(32'h08, d);
    n_total++; if (d !== 32'hBEEF) $display("FAIL read_limit got=%h exp=0000beef", d); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.wbs_dat_o !== 32'hBEEF) $display("FAIL dat_hold got=%h exp=0000beef", bus.wbs_dat_o); else n_pass++;
    wb_read(32'h40, d);
    n_total++; if (d !== 32'd0) $display("FAIL read_oob got=%h exp=0", d); else n_pass++;
    wb_write(32'h44, 32'h77, 4'hF);
    n_total++; if (count_o !== '0) $display("FAIL write_oob got=%h exp=0", count_o); else n_pass++;
    wb_write(32'h04, 32'h1200, 4'hF);
    wb_write(32'h04, 32'hABCD, 4'b0001);
    n_total++; if (count_o[15:0] !== 16'h12CD) $display("FAIL sel_low got=%h exp=12cd", count_o[15:0]); else n_pass++;
    wb_write(32'h04, 32'hABCD, 4'b0010);
    n_total++; if (count_o[15:0] !== 16'hABCD) $display("FAIL sel_high got=%h exp=abcd", count_o[15:0]); else n_pass++;
    wb_write(32'h04, 32'hFFFF_5678, 4'b1100);
    n_total++; if (count_o[15:0] !== 16'hABCD) $display("FAIL sel_upper got=%h exp=abcd", count_o[15:0]); else n_pass++;
  endtask

`ifdef COUNTER_BANK_LA_EN
  task automatic test_la_priority();
    do_reset();
    la_value = 16'h1234;
    la_load  = 4'b0100;
    wb_write(32'h24, 32'h55, 4'hF);
    n_total++; if (count_o[47:32] !== 16'h0055) $display("FAIL la_prio got=%h exp=0055", count_o[47:32]); else n_pass++;
    @(negedge clk);
    n_total++; if (count_o[47:32] !== 16'h1234) $display("FAIL la_load got=%h exp=1234", count_o[47:32]); else n_pass++;
    la_load = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n_total++;
      if (count_o !== exp_count()) $display("FAIL rnd_count i=%0d got=%h exp=%h", i, count_o, exp_count());
      else n_pass++;
      n_total++;
      if (irq_o !== exp_irq()) $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, irq_o, exp_irq());
      else n_pass++;
      n_total++;
      if (bus.wbs_ack_o !== m_ack) $display("FAIL rnd_ack i=%0d got=%b exp=%b", i, bus.wbs_ack_o, m_ack);
      else n_pass++;
      n_total++;
      if (bus.wbs_dat_o !== m_dat) $display("FAIL rnd_dat i=%0d got=%h exp=%h", i, bus.wbs_dat_o, m_dat);
      else n_pass++;
      bus.wbs_cyc_i = ($urandom_range(0, 3) != 0);
      bus.wbs_stb_i = ($urandom_range(0, 3) != 0);
      bus.wbs_we_i  = 1'($urandom_range(0, 1));
      bus.wbs_sel_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      bus.wbs_adr_i = {24'h0, 4'($urandom_range(0, 4)), 2'($urandom), 2'b00};
      bus.wbs_dat_i = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 10);
`ifdef COUNTER_BANK_LA_EN
      la_load  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      la_value = 16'($urandom_range(0, 8));
`endif
      @(negedge clk);
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    la_load = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    wb_write(32'h08, 32'd2, 4'hF);
    wb_write(32'h00, 32'h9, 4'hF);
    repeat (4) @(negedge clk);
    n_total++; if (irq_o[0] !== 1'b1) $display("FAIL arst_pre_irq got=%b exp=1", irq_o[0]); else n_pass++;
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = 32'h08; bus.wbs_sel_i = 4'hF;
    @(posedge clk);
    #2;
    n_total++; if (bus.wbs_ack_o !== 1'b1) $display("FAIL arst_pre_ack got=%b exp=1", bus.wbs_ack_o); else n_pass++;
    n_total++; if (bus.wbs_dat_o !== 32'd2) $display("FAIL arst_pre_dat got=%h exp=2", bus.wbs_dat_o); else n_pass++;
    nreset = 0;
    #1;
    n_total++; if (count_o !== '0) $display("FAIL arst_count got=%h exp=0", count_o); else n_pass++;
    n_total++; if (irq_o !== '0) $display("FAIL arst_irq got=%b exp=0", irq_o); else n_pass++;
    n_total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL arst_ack got=%b exp=0", bus.wbs_ack_o); else n_pass++;
    n_total++; if (bus.wbs_dat_o !== '0) $display("FAIL arst_dat got=%h exp=0", bus.wbs_dat_o); else n_pass++;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1;
    repeat (3) @(negedge clk);
    n_total++; if (count_o !== '0) $display("FAIL arst_idle got=%h exp=0", count_o); else n_pass++;
    n_total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL arst_idle_ack got=%b exp=0", bus.wbs_ack_o); else n_pass++;
    wb_read(32'h00, d);
    n_total++; if (d !== 32'd0) $display("FAIL arst_ctrl got=%h exp=0", d); else n_pass++;
  endtask

  initial begin
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 4'h0; bus.wbs_dat_i = '0; bus.wbs_adr_i = '0;
    test_reset();
    test_up_wrap();
    test_down_oneshot();
    test_w1c_race();
    test_bus();
`ifdef COUNTER_BANK_LA_EN
    test_la_priority();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_counter_bank.md
# wb_counter_bank

Multi-channel programmable counter/timer bank on the user-project Wishbone slave port. It provides `CHANNELS` independent counters of `BITS` width, each with up/down direction, auto-reload/compare limit, one-shot mode and a per-channel interrupt. The management SoC controls it through Wishbone, and the logic analyser can force-load counters. It sits beside the core in the user area and drives GPIO/debug and IRQ lines.

## Interface
- `CHANNELS`, default 4: number of counter channels, legal range 1..16.
- `BITS`, default 16: counter width, legal range 1..32.

- `clk`  in  1  single clock for all state.
- `nreset`  in  1  asynchronous active-low reset.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte lane strobes.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address; only `[7:2]` is decoded, and base-address match is done upstream.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, zero-extended.
- `la_load`  in  CHANNELS  per-channel LA force-load request. Present only with `COUNTER_BANK_LA_EN`.
- `la_value`  in  BITS  LA load value, shared by all channels. Present only with `COUNTER_BANK_LA_EN`.
- `count_o`  out  CHANNELS*BITS  live counts; channel n occupies `[n*BITS +: BITS]`.
- `irq_o`  out  CHANNELS  per-channel interrupt, level.

## Operation
- **Address decode.** Word index `idx = wbs_adr_i[7:2]`; channel `ch = idx[5:2]`; register `r = idx[1:0]`.
  - An access with `ch >= CHANNELS` is still acked; it reads 0 and writes are ignored.
- **Registers per channel:**
  - `r=0` CTRL:
    - bit0 EN: count enable.
    - bit1 DIR: 0 = up, 1 = down.
    - bit2 ONESHOT.
    - bit3 IRQ_EN.
    - Other bits read 0.
  - `r=1` COUNT: read/write.
  - `r=2` LIMIT: read/write.
  - `r=3` STATUS: bit0 FLAG; writing 1 clears it (W1C).
- **Byte lanes.** Writes honour `wbs_sel_i` per byte lane. Bits at or above `BITS` are dropped.
- **Counting when EN=1:**
  - Up: if COUNT == LIMIT, then COUNT <= 0 and FLAG set (terminal event); else COUNT+1.
  - Down: if COUNT == 0, then COUNT <= LIMIT and FLAG set; else COUNT-1.
  - ONESHOT=1: the terminal event also clears EN. The reload/wrap value is still applied.
  - All arithmetic is modulo 2^BITS. Nothing ever wraps past LIMIT in up mode; if COUNT > LIMIT after a write, it counts up through 2^BITS-1 to 0.
- **Interrupt.** `irq_o[n] = FLAG[n] & IRQ_EN[n]`, driven from registered state only.
- **Priority per channel, per cycle, for COUNT:** Wishbone write > LA load > count step.
  - An accepted COUNT write suppresses that cycle's step and terminal event.
- **Simultaneous events:**
  - W1C in the same cycle as a terminal event: FLAG stays 1.
  - CTRL write in the same cycle as a one-shot terminal event: the written EN wins.
  - LIMIT write takes effect from the next comparison.
- **Reset.** `nreset` low forces every register and output to 0: COUNT, LIMIT, CTRL, FLAG, `wbs_ack_o`, `wbs_dat_o`, `irq_o`, `count_o`. A reset mid-transaction drops the transaction with no ack.

## Timing
- **Acceptance.** A request is accepted when `wbs_cyc_i & wbs_stb_i & !wbs_ack_o` at a rising edge of `clk`.
- **Ack.** `wbs_ack_o` is high for exactly the following cycle. Minimum spacing between acks is therefore 2 cycles.
- **Read data.** Valid while ack is high; it is the register value before that edge's update. Outside ack, `wbs_dat_o` holds its last value.
- **Write effect.** A write takes effect at the accepting edge and is visible on `count_o` and `irq_o` the next cycle.
- **Event to output.** FLAG and `irq_o` rise in the cycle after the terminal edge, i.e. one cycle of latency from COUNT == terminal.
- **LA load.** Takes effect at the edge where `la_load[n]` is sampled high; it is level-sensitive, reloading every cycle it is held.

## Configuration
- `COUNTER_BANK_LA_EN` defined:
  - The `la_load` and `la_value` ports exist.
  - LA load participates in priority as above.
- `COUNTER_BANK_LA_EN` undefined:
  - Both ports are absent.
  - COUNT changes only by Wishbone write or counting.
  - No LA logic is synthesised.

## Test plan
- **Up count with wrap.** Reset, then write LIMIT0=5 and CTRL0=0x9 (EN, IRQ_EN) -> COUNT goes 0,1..5,0; FLAG0 and `irq_o[0]` rise the cycle after COUNT0 == 5.
- **Down one-shot.** CTRL1=0x7 (EN, DIR, ONESHOT), LIMIT1=3, COUNT1=2 -> 2,1,0,3, then EN1 clears and COUNT1 holds 3; FLAG1=1 and `irq_o[1]`=0.
- **W1C race.** Write STATUS0=1 in the exact cycle of a terminal event -> FLAG0 remains 1. Write STATUS0=1 one cycle later -> FLAG0=0 and `irq_o[0]` falls.
- **Bus protocol.** Hold stb/cyc high continuously -> ack pattern 1,0,1,0.
  - Read at `adr=0x40` with CHANNELS=4 -> ack with data 0.
  - `sel=4'b0001` write 0xABCD to COUNT (BITS=16) -> only the low byte updates to 0xCD.
- **Priority.** With `COUNTER_BANK_LA_EN`: assert `la_load[2]` with `la_value`=0x1234 in the same cycle as a Wishbone write COUNT2=0x55 -> COUNT2=0x55. Next cycle, LA load only -> COUNT2=0x1234.
- **Asynchronous reset.** Drop `nreset` mid-count and mid-ack -> all outputs are 0 immediately. After release, counters stay idle (EN=0).
